display_value_register: RTL and testbench

// - Memory-mapped peripheral holding the 32-bit value shown on the 8-digit seven-segment display.
// - CPU (RV32E core) writes over a simple valid/ready bus; display_value drives the seven-segment controller's value input.
// - Optional hardware binary->BCD conversion so software can display decimal numbers.

---
 rtl/display_pkg.sv | 34 +++
 rtl/display_value_register_if.sv | 31 +++
 rtl/bin_to_bcd_seq.sv | 102 ++++++++++
 rtl/display_value_register.sv | 135 +++++++++++++
 tb/tb_display_value_register.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Register map and shared types for the seven-segment display value peripheral.
// Contents:
//   OFF_DATA / OFF_CTRL / OFF_STATUS  byte offsets inside the 16-byte window
//   CTRL_BCD_BIT                      CTRL bit selecting binary->BCD display mode
//   STATUS_BUSY_BIT / STATUS_OVF_BIT  STATUS flag positions
//   BCD_MAX / DISP_ERR                largest 8-digit decimal value, error pattern
//   conv_state_t                      converter FSM states
//   bcd_digit_adjust                  one double-dabble digit correction
package display_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int CTRL_BCD_BIT    = 0;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  localparam logic [31:0] BCD_MAX  = 32'd99_999_999;
  localparam logic [31:0] DISP_ERR = 32'hEEEE_EEEE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_t;

  // A digit of 5 or more would become >= 10 after the next doubling, so it is
  // pre-corrected by +3 so that the carry falls into the next digit.
  function automatic logic [3:0] bcd_digit_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/display_value_register_if.sv
// CPU-side valid/ready register bus of the display value peripheral.
// Signals:
//   req_valid  request, held until req_ready
//   req_we     1 = write, 0 = read
//   req_addr   byte address
//   req_wdata  write data
//   req_wstrb  write byte enables
//   req_ready  one-cycle completion pulse
//   req_rdata  read data, valid while req_ready = 1, else 0
// Modports: master (CPU), slave (peripheral).
interface display_value_register_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready;
  logic [31:0] req_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, req_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, req_rdata
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential 32-bit binary to 8-digit BCD converter (shift-add-3, one bit per
// clock, 32 steps), followed by a single DONE cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin converting bin (also restarts a running conversion)
//   abort      drop any running conversion and return to IDLE
//   bin        value to convert, sampled on start
//   busy       conversion in progress (CONVERT or DONE)
//   done       high for the single DONE cycle; bcd is valid then
//   bcd        result digits, or DISP_ERR if bin exceeded BCD_MAX
//   ovf        range flag of the most recently completed conversion
module bin_to_bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        ovf
);

  conv_state_t state_reg, state_next;
  logic [31:0] shift_reg, shift_next;
  logic [31:0] digits_reg, digits_next;
  logic [31:0] digits_adj;
  logic [4:0]  cnt_reg, cnt_next;
  logic        range_err_reg, range_err_next;
  logic        ovf_reg, ovf_next;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit_adj
      assign digits_adj[4*gi +: 4] = bcd_digit_adjust(digits_reg[4*gi +: 4]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      digits_reg    <= '0;
      cnt_reg       <= '0;
      range_err_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      digits_reg    <= digits_next;
      cnt_reg       <= cnt_next;
      range_err_reg <= range_err_next;
      ovf_reg       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    digits_next    = digits_reg;
    cnt_next       = cnt_reg;
    range_err_next = range_err_reg;
    ovf_next       = ovf_reg;

    if (abort) begin
      state_next = IDLE;
    end else if (start) begin
      state_next     = CONVERT;
      shift_next     = bin;
      digits_next    = '0;
      cnt_next       = '0;
      // Values above eight decimal digits cannot be shown; decided up front
      // so the datapath never needs a ninth digit.
      range_err_next = (bin > BCD_MAX);
    end else begin
      case (state_reg)
        CONVERT: begin
          {digits_next, shift_next} = {digits_adj, shift_reg} << 1;
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            state_next = DONE;
          end
        end
        DONE: begin
          ovf_next   = range_err_reg;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign bcd  = range_err_reg ? DISP_ERR : digits_reg;
  assign ovf  = ovf_reg;

endmodule

// File: rtl/display_value_register.sv
// Memory-mapped register holding the 32-bit value shown on the 8-digit
// seven-segment display.
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   bus            valid/ready register bus (slave side)
//   display_value  nibble-per-digit value for the seven-segment controller
// Registers (offsets in the 16-byte window at BASE_ADDR):
//   0x0 DATA    R/W, byte-enabled
//   0x4 CTRL    bit0 bcd (R/W) when DISPLAY_BCD_EN, else reads 0
//   0x8 STATUS  bit0 busy, bit1 ovf (read-only), 0 without DISPLAY_BCD_EN
// Build option: define DISPLAY_BCD_EN to include the binary->BCD converter.
// Without it, display_value simply mirrors DATA.
module display_value_register
  import display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  display_value_register_if.slave        bus,
  output logic [31:0]                    display_value
);

  logic        req_ready_reg;
  logic [31:0] req_rdata_reg;
  logic [31:0] data_reg, data_next;
  logic [31:0] display_reg;
  logic [31:0] rdata_mux;
  logic [31:0] ctrl_val, status_val;
  logic        accept, hit, wr_data;
  logic [3:0]  offset;

  // No accept while req_ready is high: each request costs two cycles.
  assign accept  = bus.req_valid && !req_ready_reg;
  assign hit     = (bus.req_addr[31:4] == BASE_ADDR[31:4]);
  assign offset  = bus.req_addr[3:0];
  assign wr_data = accept && bus.req_we && hit && (offset == OFF_DATA);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_data_byte
      assign data_next[8*gi +: 8] = (wr_data && bus.req_wstrb[gi]) ?
                                    bus.req_wdata[8*gi +: 8] : data_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_reg <= 1'b0;
      req_rdata_reg <= '0;
      data_reg      <= RESET_VAL;
    end else begin
      req_ready_reg <= accept;
      req_rdata_reg <= (accept && !bus.req_we) ? rdata_mux : '0;
      data_reg      <= data_next;
    end
  end

`ifdef DISPLAY_BCD_EN
  logic        bcd_reg, bcd_next;
  logic        wr_ctrl;
  logic        start_reg, abort_reg;
  logic        conv_busy, conv_done, conv_ovf;
  logic [31:0] conv_bcd;

  assign wr_ctrl  = accept && bus.req_we && hit && (offset == OFF_CTRL) &&
                    bus.req_wstrb[CTRL_BCD_BIT / 8];
  assign bcd_next = wr_ctrl ? bus.req_wdata[CTRL_BCD_BIT] : bcd_reg;

  // start/abort are registered so the converter samples the already-updated
  // DATA register; this puts display_value 34 cycles after the ready pulse.
  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_reg),
    .abort (abort_reg),
    .bin   (data_reg),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg     <= 1'b0;
      start_reg   <= 1'b0;
      abort_reg   <= 1'b0;
      display_reg <= RESET_VAL;
    end else begin
      bcd_reg   <= bcd_next;
      start_reg <= bcd_next && (wr_data || (wr_ctrl && !bcd_reg));
      abort_reg <= bcd_reg && !bcd_next;
      // Raw mode tracks DATA directly; BCD mode only changes on completion,
      // so no intermediate digits ever reach the display.
      if (!bcd_next) begin
        display_reg <= data_next;
      end else if (conv_done) begin
        display_reg <= conv_bcd;
      end
    end
  end

  always_comb begin
    ctrl_val                    = '0;
    ctrl_val[CTRL_BCD_BIT]      = bcd_reg;
    status_val                  = '0;
    status_val[STATUS_BUSY_BIT] = conv_busy;
    status_val[STATUS_OVF_BIT]  = conv_ovf;
  end
`else
  assign display_reg = data_reg;
  assign ctrl_val    = '0;
  assign status_val  = '0;
`endif

  always_comb begin
    rdata_mux = '0;
    if (hit) begin
      case (offset)
        OFF_DATA:   rdata_mux = data_reg;
        OFF_CTRL:   rdata_mux = ctrl_val;
        OFF_STATUS: rdata_mux = status_val;
        default:    rdata_mux = '0;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.req_rdata  = req_rdata_reg;
  assign display_value  = display_reg;

endmodule

// File: tb/tb_display_value_register.sv
module tb_display_value_register;
  import display_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] display_value;

  display_value_register_if bus ();

  display_value_register #(
    .BASE_ADDR (BASE),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .display_value (display_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ready_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every change of display_value with the clock edge that caused it.
  typedef struct {
    int          c;
    logic [31:0] v;
  } dv_evt_t;

  dv_evt_t     evq[$];
  logic [31:0] dv_prev;

  always @(negedge clk) begin
    if (display_value !== dv_prev) begin
      dv_evt_t e;
      e.c = cyc;
      e.v = display_value;
      evq.push_back(e);
    end
    dv_prev <= display_value;
  end

  // Scoreboard of expected read data, one entry per issued request.
  logic [31:0] sbq[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [31:0] exp_disp;
    string       nm;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] er, input logic [31:0] ed,
                              input string nm);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rdata = er; v.exp_disp = ed; v.nm = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input string nm);
    int w;
    logic [31:0] exp;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = strb;
    sbq.push_back(exp_rdata);
    @(posedge clk);
    #1;
    last_ready_cyc = cyc;
    check({nm, " ready_latency1"}, {31'b0, bus.req_ready}, 32'd1);
    w = 0;
    while (!bus.req_ready && w < 8) begin
      @(posedge clk);
      #1;
      w++;
    end
    exp = sbq.pop_front();
    if (bus.req_ready) begin
      check({nm, " rdata"}, bus.req_rdata, exp);
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: req_ready got 0 expected 1", nm);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    @(posedge clk);
    #1;
    check({nm, " ready_pulse_end"}, {31'b0, bus.req_ready}, 32'd0);
  endtask

  // Expect exactly one display change since the log was last cleared.
  task automatic check_events(input int start, input logic [31:0] v, input int lat, input string nm);
    check({nm, " disp_changes"}, evq.size(), 32'd1);
    if (evq.size() > 0) begin
      check({nm, " disp_value"}, evq[0].v, v);
      check({nm, " disp_latency"}, evq[0].c - start, lat);
    end
    evq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;

    tbl[0]  = mk(0, BASE + 32'(OFF_DATA),   32'h0,         4'h0, 32'h0,         32'h0,         "rd_data_reset");
    tbl[1]  = mk(0, BASE + 32'(OFF_CTRL),   32'h0,         4'h0, 32'h0,         32'h0,         "rd_ctrl_reset");
    tbl[2]  = mk(0, BASE + 32'(OFF_STATUS), 32'h0,         4'h0, 32'h0,         32'h0,         "rd_status_reset");
    tbl[3]  = mk(1, BASE + 32'(OFF_DATA),   32'h1234_ABCD, 4'hF, 32'h0,         32'h1234_ABCD, "wr_data_full");
    tbl[4]  = mk(1, BASE + 32'(OFF_DATA),   32'h0000_5500, 4'h2, 32'h0,         32'h1234_55CD, "wr_data_byte1");
    tbl[5]  = mk(0, BASE + 32'(OFF_DATA),   32'h0,         4'h0, 32'h1234_55CD, 32'h1234_55CD, "rd_data");
    tbl[6]  = mk(1, BASE + 32'(OFF_DATA),   32'hFFFF_FFFF, 4'h0, 32'h0,         32'h1234_55CD, "wr_strb0_noop");
    tbl[7]  = mk(0, BASE + 32'h0000_000C,   32'h0,         4'h0, 32'h0,         32'h1234_55CD, "rd_unmapped_c");
    tbl[8]  = mk(1, BASE + 32'h0000_0020,   32'hDEAD_BEEF, 4'hF, 32'h0,         32'h1234_55CD, "wr_out_of_window");
    tbl[9]  = mk(0, BASE + 32'h0000_0020,   32'h0,         4'h0, 32'h0,         32'h1234_55CD, "rd_out_of_window");
    tbl[10] = mk(0, BASE + 32'(OFF_DATA),   32'h0,         4'h0, 32'h1234_55CD, 32'h1234_55CD, "rd_data_again");

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset display_value", display_value, 32'h0);
    check("reset req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("reset req_rdata", bus.req_rdata, 32'h0);

    for (int i = 0; i < 11; i++) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].exp_rdata, tbl[i].nm);
      check({tbl[i].nm, " display"}, display_value, tbl[i].exp_disp);
    end

`ifdef DISPLAY_BCD_EN
    do_req(1, BASE + 32'(OFF_DATA), 32'h0, 4'hF, 32'h0, "bcd_prep_data0");
    do_req(1, BASE + 32'(OFF_CTRL), 32'h1, 4'hF, 32'h0, "bcd_ctrl_set");
    do_req(0, BASE + 32'(OFF_CTRL), 32'h0, 4'h0, 32'h1, "bcd_ctrl_rd");
    idle_until(last_ready_cyc + 40);
    evq.delete();

    // Conversion of 12345678 with busy sampled at start, end and after.
    do_req(1, BASE + 32'(OFF_DATA), 32'd12_345_678, 4'hF, 32'h0, "bcd_wr_12345678");
    a = last_ready_cyc;
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h1, "bcd_status_busy_early");
    idle_until(a + 32);
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h1, "bcd_status_busy_last");
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h0, "bcd_status_idle");
    idle_until(a + 40);
    check_events(a, 32'h1234_5678, 34, "bcd_12345678");

    do_req(1, BASE + 32'(OFF_DATA), 32'd100_000_000, 4'hF, 32'h0, "bcd_wr_ovf");
    a = last_ready_cyc;
    idle_until(a + 40);
    check_events(a, 32'hEEEE_EEEE, 34, "bcd_ovf");
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h2, "bcd_status_ovf");

    do_req(1, BASE + 32'(OFF_DATA), 32'd99_999_999, 4'hF, 32'h0, "bcd_wr_max");
    a = last_ready_cyc;
    idle_until(a + 40);
    check_events(a, 32'h9999_9999, 34, "bcd_max");
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h0, "bcd_status_max");

    // Restart: 42 must never appear, 7 lands 34 cycles after second write.
    do_req(1, BASE + 32'(OFF_DATA), 32'd42, 4'hF, 32'h0, "bcd_wr_42");
    a = last_ready_cyc;
    idle_until(a + 9);
    do_req(1, BASE + 32'(OFF_DATA), 32'd7, 4'hF, 32'h0, "bcd_wr_7_restart");
    a = last_ready_cyc;
    idle_until(a + 40);
    check_events(a, 32'h0000_0007, 34, "bcd_restart");

    // Clearing bcd mid-conversion shows raw DATA at once and nothing later.
    do_req(1, BASE + 32'(OFF_DATA), 32'd5, 4'hF, 32'h0, "bcd_wr_5");
    a = last_ready_cyc;
    idle_until(a + 4);
    do_req(1, BASE + 32'(OFF_CTRL), 32'h0, 4'hF, 32'h0, "bcd_ctrl_clear");
    a = last_ready_cyc;
    idle_until(a + 40);
    check_events(a, 32'h0000_0005, 0, "bcd_abort_raw");
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h0, "bcd_status_after_abort");
    do_req(0, BASE + 32'(OFF_CTRL), 32'h0, 4'h0, 32'h0, "bcd_ctrl_rd_cleared");
`else
    do_req(1, BASE + 32'(OFF_CTRL), 32'h1, 4'hF, 32'h0, "nobcd_ctrl_wr");
    do_req(0, BASE + 32'(OFF_CTRL), 32'h0, 4'h0, 32'h0, "nobcd_ctrl_rd");
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h0, "nobcd_status_rd");
    do_req(1, BASE + 32'(OFF_CTRL), 32'h0, 4'hF, 32'h0, "nobcd_ctrl_wr0");
`endif

    // Reset in the middle of activity (a conversion when BCD is built in).
    do_req(1, BASE + 32'(OFF_CTRL), 32'h1, 4'hF, 32'h0, "rst_ctrl_set");
    do_req(1, BASE + 32'(OFF_DATA), 32'd12_345_678, 4'hF, 32'h0, "rst_wr_data");
    a = last_ready_cyc;
    idle_until(a + 10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst display_value", display_value, 32'h0);
    check("midrst req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("midrst req_rdata", bus.req_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    evq.delete();
    idle_until(cyc + 40);
    check("midrst no_later_disp_change", evq.size(), 32'd0);
    do_req(0, BASE + 32'(OFF_DATA), 32'h0, 4'h0, 32'h0, "midrst_rd_data");
    do_req(0, BASE + 32'(OFF_CTRL), 32'h0, 4'h0, 32'h0, "midrst_rd_ctrl");
    do_req(0, BASE + 32'(OFF_STATUS), 32'h0, 4'h0, 32'h0, "midrst_rd_status");
    check("midrst display_final", display_value, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
